// File: rtl/fifo_profile_monitor.sv
// fifo_profile_monitor
//   Multi-channel FIFO profiler. Taps the push/pop handshakes of NUM_CH FIFOs during a run.
//   For each channel it tracks occupancy, max depth and a sticky underflow flag. It also
//   counts the per-cycle (write-blocked, read-blocked) pair classes. After finish it
//   streams one record per channel, then a latency record, over a valid/ready port.
// Ports
//   clk, rst                       clock, async active-low reset
//   start, finish                  run control
//   wr_valid/wr_ready              per-channel push handshake
//   rd_valid/rd_ready              per-channel pop handshake
//   dump_valid/dump_ready          record stream handshake
//   dump_ch                        record index, NUM_CH = latency record
//   dump_data                      max depth (zero-extended) or latency
//   dump_scen, dump_err            channel scenario code and underflow flag
//   dump_last                      marks the latency record
//   done                           stream complete
module fifo_profile_monitor #(
    parameter int                NUM_CH           = 4,
    parameter int                DEPTH_W          = 16,
    parameter int                CNT_W            = 16,
    parameter int                LAT_W            = 32,
    parameter logic [NUM_CH-1:0] SINGLE_CHAN_MASK = '0,
    localparam int               CH_W             = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic [NUM_CH-1:0] wr_valid,
    input  logic [NUM_CH-1:0] wr_ready,
    input  logic [NUM_CH-1:0] rd_valid,
    input  logic [NUM_CH-1:0] rd_ready,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [CH_W-1:0]   dump_ch,
    output logic [LAT_W-1:0]  dump_data,
    output logic [3:0]        dump_scen,
    output logic              dump_err,
    output logic              dump_last,
    output logic              done
);
    localparam int SW = CNT_W + 2;  // scenario arithmetic width, wide enough for 2*(p01+p10)

    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
    state_t state, state_nxt;

    logic                            clear, run, cnt_en;
    logic [CNT_W-1:0]                samples;
    logic [LAT_W-1:0]                lat;
    logic [NUM_CH-1:0][DEPTH_W-1:0]  max_arr;
    logic [NUM_CH-1:0][3:0]          scen_arr;
    logic [NUM_CH-1:0]               err_arr;

    assign clear  = start && (state == IDLE || state == DONE);
    assign run    = (state == RUN);
    // Once samples saturates, every pair counter stops with it so ratios stay consistent.
    assign cnt_en = run && (samples != '1);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (finish) state_nxt = DUMP;
            DUMP:    if (dump_valid && dump_ready && dump_last) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
    end

    // ---------------- global counters ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samples <= '0;
            lat     <= '0;
        end else if (clear) begin
            samples <= '0;
            lat     <= '0;
        end else if (run) begin
            if (cnt_en)     samples <= samples + 1'b1;
            if (lat != '1)  lat     <= lat + 1'b1;
        end
    end

    // ---------------- per-channel trackers ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic               push, pop, wb, rb;
        logic [DEPTH_W-1:0] occ, occ_nxt, max_q;
        logic               err_q;
        logic [CNT_W-1:0]   p00, p01, p10, p11;
        logic [SW-1:0]      s, a, b, c, d;
        logic [3:0]         scen;

        assign push = wr_valid[g] & wr_ready[g];
        assign pop  = rd_valid[g] & rd_ready[g];
        assign wb   = wr_valid[g] & ~wr_ready[g];
        assign rb   = rd_ready[g] & ~rd_valid[g];

        always_comb begin
            occ_nxt = occ;
            if (push && !pop && occ != '1)            occ_nxt = occ + 1'b1;
            else if (pop && !push && occ != '0)       occ_nxt = occ - 1'b1;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                occ <= '0; max_q <= '0; err_q <= 1'b0;
                p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
            end else if (clear) begin
                occ <= '0; max_q <= '0; err_q <= 1'b0;
                p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
            end else if (run) begin
                occ <= occ_nxt;
                if (occ_nxt > max_q)             max_q <= occ_nxt;
                if (pop && !push && occ == '0)   err_q <= 1'b1;
                if (cnt_en) begin
                    case ({wb, rb})
                        2'b00:   p00 <= p00 + 1'b1;
                        2'b01:   p01 <= p01 + 1'b1;
                        2'b10:   p10 <= p10 + 1'b1;
                        default: p11 <= p11 + 1'b1;
                    endcase
                end
            end
        end

        always_comb begin
            s = SW'(samples);
            a = SW'(p00);
            b = SW'(p01);
            c = SW'(p10);
            d = SW'(p11);
            if (s == '0)                                   scen = 4'd0;
            else if (a == s)                               scen = 4'd5;
            else if ((a + c) == s && SINGLE_CHAN_MASK[g])  scen = 4'd6;
            else if ((a + c) == s)                         scen = 4'd4;
            else if ((b << 1) > s)                         scen = 4'd3;
            else if ((d << 1) > s)                         scen = 4'd1;
            else if (((b + c) << 1) > s)                   scen = 4'd2;
            else                                           scen = 4'd0;
        end

        assign max_arr[g]  = max_q;
        assign scen_arr[g] = scen;
        assign err_arr[g]  = err_q;
    end

    // ---------------- dump stream ----------------
    logic [CH_W-1:0]  rec_idx;
    logic [LAT_W-1:0] rec_data;
    logic [3:0]       rec_scen;
    logic             rec_err, rec_last;

    // First record after entering DUMP is index 0; afterwards each transfer advances by one.
    assign rec_idx = dump_valid ? dump_ch + 1'b1 : '0;

    always_comb begin
        rec_data = lat;
        rec_scen = 4'd0;
        rec_err  = 1'b0;
        rec_last = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rec_idx == CH_W'(i)) begin
                rec_data = LAT_W'(max_arr[i]);
                rec_scen = scen_arr[i];
                rec_err  = err_arr[i];
                rec_last = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump_valid <= 1'b0;
            dump_ch    <= '0;
            dump_data  <= '0;
            dump_scen  <= '0;
            dump_err   <= 1'b0;
            dump_last  <= 1'b0;
        end else if (state == DUMP) begin
            if (!dump_valid || (dump_ready && !dump_last)) begin
                dump_valid <= 1'b1;
                dump_ch    <= rec_idx;
                dump_data  <= rec_data;
                dump_scen  <= rec_scen;
                dump_err   <= rec_err;
                dump_last  <= rec_last;
            end else if (dump_ready) begin
                dump_valid <= 1'b0;
            end
        end else begin
            dump_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_profile_monitor.sv
// Scoreboard bench for fifo_profile_monitor: directed runs push hand-computed records,
// negedge monitors pop and compare on every dump transfer and check payload hold.
module tb_fifo_profile_monitor;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main DUT (4 channels, mask bit 1 set)
    logic          start, finish, dump_ready;
    logic [NC-1:0] wr_valid, wr_ready, rd_valid, rd_ready;
    logic          dump_valid, dump_err, dump_last, done;
    logic [2:0]    dump_ch;
    logic [31:0]   dump_data;
    logic [3:0]    dump_scen;

    // narrow-counter DUT
    logic        start_b, finish_b, dump_ready_b;
    logic [0:0]  wr_valid_b, wr_ready_b, rd_valid_b, rd_ready_b;
    logic        dump_valid_b, dump_err_b, dump_last_b, done_b;
    logic [0:0]  dump_ch_b;
    logic [31:0] dump_data_b;
    logic [3:0]  dump_scen_b;

    fifo_profile_monitor #(.NUM_CH(NC), .DEPTH_W(16), .CNT_W(16), .LAT_W(32),
                           .SINGLE_CHAN_MASK(4'b0010)) u_dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_ch(dump_ch),
        .dump_data(dump_data), .dump_scen(dump_scen), .dump_err(dump_err),
        .dump_last(dump_last), .done(done));

    fifo_profile_monitor #(.NUM_CH(1), .DEPTH_W(4), .CNT_W(4), .LAT_W(32),
                           .SINGLE_CHAN_MASK(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .finish(finish_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready_b),
        .dump_valid(dump_valid_b), .dump_ready(dump_ready_b), .dump_ch(dump_ch_b),
        .dump_data(dump_data_b), .dump_scen(dump_scen_b), .dump_err(dump_err_b),
        .dump_last(dump_last_b), .done(done_b));

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] data;
        logic [3:0]  scen;
        logic        err;
        logic        last;
    } rec_t;

    rec_t exp_a[$];
    rec_t exp_b[$];
    int   checks = 0;
    int   errors = 0;
    bit   holding [2];
    rec_t held    [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_rec(input int k, input int ch, input int data, input int scen,
                            input bit err, input bit last);
        rec_t r;
        r.ch = 3'(ch); r.data = 32'(data); r.scen = 4'(scen); r.err = err; r.last = last;
        if (k == 0) exp_a.push_back(r);
        else        exp_b.push_back(r);
    endtask

    task automatic scoreboard(input int k, input logic v, input logic r, input rec_t act);
        rec_t e;
        if (!rst) begin
            holding[k] = 1'b0;
            return;
        end
        if (holding[k]) begin
            checks++;
            if (!v || act != held[k]) begin
                errors++;
                $display("FAIL hold_stable dut%0d: got valid=%0b rec=%h expected valid=1 rec=%h",
                         k, v, act, held[k]);
            end
        end
        holding[k] = 1'b0;
        if (v && !r) begin
            holding[k] = 1'b1;
            held[k]    = act;
        end else if (v && r) begin
            checks++;
            if ((k == 0 && exp_a.size() == 0) || (k == 1 && exp_b.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_rec dut%0d: got ch=%0d data=%0d expected no record",
                         k, act.ch, act.data);
            end else begin
                e = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
                if (act != e) begin
                    errors++;
                    $display("FAIL rec dut%0d: got ch=%0d data=%0d scen=%0d err=%0b last=%0b expected ch=%0d data=%0d scen=%0d err=%0b last=%0b",
                             k, act.ch, act.data, act.scen, act.err, act.last,
                             e.ch, e.data, e.scen, e.err, e.last);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        scoreboard(0, dump_valid, dump_ready,
                   rec_t'({dump_ch, dump_data, dump_scen, dump_err, dump_last}));
        scoreboard(1, dump_valid_b, dump_ready_b,
                   rec_t'({2'b00, dump_ch_b, dump_data_b, dump_scen_b, dump_err_b, dump_last_b}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle channel stimulus for directed test t, RUN cycle c (t=0: all idle).
    task automatic drive(input int t, input int c);
        wr_valid = '0; wr_ready = '0; rd_valid = '0; rd_ready = '0;
        case (t)
            1: if (c <= 5) begin wr_valid[0] = 1'b1; wr_ready[0] = 1'b1; end
            2: begin wr_valid[0] = 1'b1; wr_valid[1] = 1'b1; end
            3: if (c <= 6) begin rd_ready[2] = 1'b1; wr_valid[3] = 1'b1; rd_ready[3] = 1'b1; end
            4: begin
                if (c == 1) begin rd_valid[3] = 1'b1; rd_ready[3] = 1'b1; end
                if (c == 2 || c == 3) begin wr_valid[3] = 1'b1; wr_ready[3] = 1'b1; end
                if (c == 4) begin
                    wr_valid[3] = 1'b1; wr_ready[3] = 1'b1; rd_valid[3] = 1'b1; rd_ready[3] = 1'b1;
                end
                if (c <= 2) wr_valid[1] = 1'b1;
                if (c == 3 || c == 4) rd_ready[1] = 1'b1;
            end
            default: ;
        endcase
    endtask

    // One complete run on the main DUT: start (optionally with finish), n RUN cycles with
    // finish on the last, then drain the dump, optionally stalling on record 1.
    task automatic run_a(input int t, input int n, input int stall_cnt, input bit sf);
        int stalls = 0;
        start = 1'b1; finish = sf;
        tick();
        start = 1'b0; finish = 1'b0;
        check("done_clear_on_start", 32'(done), 0);
        for (int c = 1; c <= n; c++) begin
            drive(t, c);
            finish = (c == n);
            tick();
        end
        finish = 1'b0;
        drive(0, 0);
        check("valid_low_entering_dump", 32'(dump_valid), 0);
        for (int k = 0; k < 40 && !done; k++) begin
            dump_ready = !(stall_cnt > 0 && dump_valid && dump_ch == 3'd1 && stalls < stall_cnt);
            if (!dump_ready) stalls++;
            tick();
            if (k == 0) check("first_valid_latency", 32'(dump_valid), 1);
        end
        dump_ready = 1'b1;
        check("done_after_dump", 32'(done), 1);
        if (stall_cnt > 0) check("stall_cycles", 32'(stalls), 32'(stall_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        start = 0; finish = 0; dump_ready = 1'b1;
        wr_valid = '0; wr_ready = '0; rd_valid = '0; rd_ready = '0;
        start_b = 0; finish_b = 0; dump_ready_b = 1'b1;
        wr_valid_b = '0; wr_ready_b = '0; rd_valid_b = '0; rd_ready_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dump_valid", 32'(dump_valid), 0);
        check("reset_done", 32'(done), 0);
        check("reset_dump_data", dump_data, 0);
        check("reset_dump_last", 32'(dump_last), 0);
        rst = 1'b1;
        tick();

        // T1: 5 pushes on ch0, finish on RUN cycle 10
        push_rec(0, 0, 5, 5, 0, 0); push_rec(0, 1, 0, 5, 0, 0);
        push_rec(0, 2, 0, 5, 0, 0); push_rec(0, 3, 0, 5, 0, 0);
        push_rec(0, 4, 10, 0, 0, 1);
        run_a(1, 10, 0, 1'b0);

        // T2: write-blocked all 8 cycles on ch1 (single) and ch0 (not); start+finish from DONE
        push_rec(0, 0, 0, 4, 0, 0); push_rec(0, 1, 0, 6, 0, 0);
        push_rec(0, 2, 0, 5, 0, 0); push_rec(0, 3, 0, 5, 0, 0);
        push_rec(0, 4, 8, 0, 0, 1);
        run_a(2, 8, 0, 1'b1);

        // T3: ch2 read-blocked 6/10 -> 3, ch3 both-blocked 6/10 -> 1
        push_rec(0, 0, 0, 5, 0, 0); push_rec(0, 1, 0, 5, 0, 0);
        push_rec(0, 2, 0, 3, 0, 0); push_rec(0, 3, 0, 1, 0, 0);
        push_rec(0, 4, 10, 0, 0, 1);
        run_a(3, 10, 0, 1'b0);

        // T4: ch3 underflow then push/pop at occ 2; ch1 mixed blocking -> 2; 4-cycle stall on rec1
        push_rec(0, 0, 0, 5, 0, 0); push_rec(0, 1, 0, 2, 0, 0);
        push_rec(0, 2, 0, 5, 0, 0); push_rec(0, 3, 2, 5, 1, 0);
        push_rec(0, 4, 6, 0, 0, 1);
        run_a(4, 6, 4, 1'b0);

        // T5: reset while rec1 is held
        push_rec(0, 0, 0, 5, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            finish = (c == 3);
            tick();
        end
        finish = 1'b0;
        tick();
        tick();
        check("t5_rec1_presented", 32'(dump_ch), 1);
        dump_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t5_reset_valid", 32'(dump_valid), 0);
        check("t5_reset_done", 32'(done), 0);
        check("t5_queue_drained", 32'(exp_a.size()), 0);
        tick();
        rst = 1'b1;
        dump_ready = 1'b1;
        tick();
        finish = 1'b1; tick(); finish = 1'b0;
        tick(); tick();
        check("finish_ignored_idle_valid", 32'(dump_valid), 0);
        check("finish_ignored_idle_done", 32'(done), 0);
        // start+finish together in IDLE: start wins, short idle run follows
        push_rec(0, 0, 0, 5, 0, 0); push_rec(0, 1, 0, 5, 0, 0);
        push_rec(0, 2, 0, 5, 0, 0); push_rec(0, 3, 0, 5, 0, 0);
        push_rec(0, 4, 4, 0, 0, 1);
        run_a(0, 4, 0, 1'b1);

        // T6: narrow counters, 20 pushes over 20 cycles
        push_rec(1, 0, 15, 5, 0, 0);
        push_rec(1, 1, 20, 0, 0, 1);
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            wr_valid_b = 1'b1; wr_ready_b = 1'b1;
            finish_b = (c == 20);
            tick();
        end
        wr_valid_b = 1'b0; wr_ready_b = 1'b0; finish_b = 1'b0;
        for (int k = 0; k < 20 && !done_b; k++) tick();
        check("t6_done", 32'(done_b), 1);

        check("scoreboard_a_empty", 32'(exp_a.size()), 0);
        check("scoreboard_b_empty", 32'(exp_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
